control_sequencer: RTL

//  Hardwired control unit directly upstream of CPU_Datapath. It steps a one-state-per-clock
//  T-state FSM: fetch (T0-T2), then decode IR and execute (T3-T6). It drives every datapath
//  in/out/select strobe and ALUSelection, replacing hand-driven bench stimulus. It executes the
//  ALU subset only: 3-reg ALU ops, unary NEG/NOT, MUL/DIV to HI/LO, NOP and HALT.

---
 rtl/cpu_ctrl_pkg.sv | 63 ++++++
 rtl/reg_select_decoder.sv | 15 +
 rtl/control_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: opcodes, T-state encodings, IR field positions.
package cpu_ctrl_pkg;

  localparam int NREG = 16;
  localparam int OPW  = 5;
  localparam int RSW  = 4;

  // IR field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  // Opcodes
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_T0     = 4'b0001,
    S_T1     = 4'b0010,
    S_T2     = 4'b0011,
    S_T3     = 4'b0100,
    S_T4     = 4'b0101,
    S_T5     = 4'b0110,
    S_T6     = 4'b0111,
    S_HALTED = 4'b1000
  } state_t;

  typedef enum logic [2:0] {
    C_ALU3, C_UNARY, C_MULDIV, C_NOP, C_HALT, C_ILLEGAL
  } iclass_t;

  // Map an opcode onto the execute-sequence shape it uses
  function automatic iclass_t classify(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: classify = C_ALU3;
      OP_NEG, OP_NOT:                 classify = C_UNARY;
      OP_MUL, OP_DIV:                 classify = C_MULDIV;
      OP_NOP:                         classify = C_NOP;
      OP_HALT:                        classify = C_HALT;
      default:                        classify = C_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot register select with enable; all-zero when disabled.
module reg_select_decoder #(
  parameter int NREG = 16,
  parameter int SELW = 4
) (
  input  logic            en_i,
  input  logic [SELW-1:0] sel_i,
  output logic [NREG-1:0] onehot_o
);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
    assign onehot_o[gi] = en_i && (sel_i == SELW'(gi));
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch in T0-T2, decode/execute the ALU subset in T3-T6.
// All strobes are a combinational decode of the current state and IR fields.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREG = cpu_ctrl_pkg::NREG,
  parameter int OPW  = cpu_ctrl_pkg::OPW
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [31:0]     IR,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            IRin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            Read,
  output logic            Yin,
  output logic            Yout,
  output logic            Zin,
  output logic            ZLOin,
  output logic            ZHIin,
  output logic            ZLOout,
  output logic            ZHIout,
  output logic            ZLowSelect,
  output logic            ZHighSelect,
  output logic            HIin,
  output logic            Loin,
  output logic [OPW-1:0]  ALUSelection,
  output logic            halted,
  output logic            illegal_op,
  output logic            instr_done,
  output logic [3:0]      state_out
);

  state_t          state_q, state_d;
  iclass_t         icls;
  logic [OPW-1:0]  op;
  logic [RSW-1:0]  ra, rb, rc;
  logic            rin_en, rout_en;
  logic [RSW-1:0]  rin_sel, rout_sel;
  logic            unused_ir;

  assign op        = IR[OP_MSB:OP_LSB];
  assign ra        = IR[RA_MSB:RA_LSB];
  assign rb        = IR[RB_MSB:RB_LSB];
  assign rc        = IR[RC_MSB:RC_LSB];
  assign unused_ir = ^IR[RC_LSB-1:0];
  assign icls      = classify(op);
  assign state_out = state_q;

  // State register; clr overrides every transition, including HALTED
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and strobe decode; a finishing instruction re-samples run
  always_comb begin
    state_d      = state_q;
    rin_en       = 1'b0;
    rin_sel      = ra;
    rout_en      = 1'b0;
    rout_sel     = rb;
    PCout        = 1'b0;
    PCin         = 1'b0;
    IncPC        = 1'b0;
    MARin        = 1'b0;
    IRin         = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    Read         = 1'b0;
    Yin          = 1'b0;
    Yout         = 1'b0;
    Zin          = 1'b0;
    ZLOin        = 1'b0;
    ZHIin        = 1'b0;
    ZLOout       = 1'b0;
    ZHIout       = 1'b0;
    ZLowSelect   = 1'b0;
    ZHighSelect  = 1'b0;
    HIin         = 1'b0;
    Loin         = 1'b0;
    ALUSelection = '0;
    halted       = 1'b0;
    illegal_op   = 1'b0;
    instr_done   = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; ZLOin = 1'b1;
        ALUSelection = OP_ADD;
        state_d = S_T1;
      end
      S_T1: begin
        ZLOout = 1'b1; ZLowSelect = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T4;
        case (icls)
          C_ALU3: begin
            rout_en = 1'b1; rout_sel = rb; Yin = 1'b1;
          end
          C_UNARY: begin
            rout_en = 1'b1; rout_sel = rb; Zin = 1'b1; ZLOin = 1'b1;
            ALUSelection = op;
          end
          C_MULDIV: begin
            rout_en = 1'b1; rout_sel = ra; Yin = 1'b1;
          end
          C_HALT: begin
            instr_done = 1'b1;
            state_d    = S_HALTED;
          end
          default: begin
            // NOP and undefined opcodes both retire here
            illegal_op = (icls == C_ILLEGAL);
            instr_done = 1'b1;
            state_d    = run ? S_T0 : S_IDLE;
          end
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (icls)
          C_ALU3: begin
            rout_en = 1'b1; rout_sel = rc; Yout = 1'b1; Zin = 1'b1; ZLOin = 1'b1;
            ALUSelection = op;
          end
          C_UNARY: begin
            ZLOout = 1'b1; ZLowSelect = 1'b1; rin_en = 1'b1; rin_sel = ra;
            instr_done = 1'b1;
            state_d    = run ? S_T0 : S_IDLE;
          end
          C_MULDIV: begin
            rout_en = 1'b1; rout_sel = rb; Yout = 1'b1;
            Zin = 1'b1; ZLOin = 1'b1; ZHIin = 1'b1;
            ALUSelection = op;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_T5: begin
        case (icls)
          C_ALU3: begin
            ZLOout = 1'b1; ZLowSelect = 1'b1; rin_en = 1'b1; rin_sel = ra;
            instr_done = 1'b1;
            state_d    = run ? S_T0 : S_IDLE;
          end
          C_MULDIV: begin
            ZLOout = 1'b1; ZLowSelect = 1'b1; Loin = 1'b1;
            state_d = S_T6;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_T6: begin
        if (icls == C_MULDIV) begin
          ZHIout = 1'b1; ZHighSelect = 1'b1; HIin = 1'b1;
          instr_done = 1'b1;
          state_d    = run ? S_T0 : S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALTED: halted = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

  reg_select_decoder #(.NREG(NREG), .SELW(RSW)) u_rin_dec (
    .en_i     (rin_en),
    .sel_i    (rin_sel),
    .onehot_o (Rin)
  );

  reg_select_decoder #(.NREG(NREG), .SELW(RSW)) u_rout_dec (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (Rout)
  );

endmodule
